// File: rtl/cpu_pkg.sv
// Shared types and defaults for the memory arbiter slice.
// Arbiter FSM states, transaction owner encoding and default bus widths.
package cpu_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned BEW    = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_WAIT = 1'b1
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around the arbiter.
// slave = arbiter view, master = the surrounding fetch/LSU/memory view.
interface mem_arbiter_if
  import cpu_pkg::*;
#(
  parameter int unsigned AW = AW_DEF,
  parameter int unsigned DW = DW_DEF
) ();

  logic           if_req;
  logic [AW-1:0]  if_addr;
  logic           if_flush;
  logic           if_gnt;
  logic           if_rvalid;
  logic [DW-1:0]  if_rdata;

  logic           dm_req;
  logic           dm_we;
  logic [BEW-1:0] dm_be;
  logic [AW-1:0]  dm_addr;
  logic [DW-1:0]  dm_wdata;
  logic           dm_gnt;
  logic           dm_rvalid;
  logic [DW-1:0]  dm_rdata;

  logic           mem_req;
  logic           mem_we;
  logic [BEW-1:0] mem_be;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_ready;
  logic           mem_rvalid;
  logic [DW-1:0]  mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_be, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating counter of cycles the fetch port has been kept waiting.
// Clear wins over increment; at_limit tells the arbiter to force a fetch grant.
module arb_starve_ctr
  import cpu_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_at_limit
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_limit;

  assign w_at_limit = (r_cnt == LIM);
  assign o_at_limit = w_at_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_at_limit) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between fetch and LSU.
// Data port has priority; a starvation counter eventually forces a fetch grant.
module mem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned AW           = AW_DEF,
  parameter int unsigned DW           = DW_DEF,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  arb_state_e r_state;
  arb_state_e w_state_next;
  arb_owner_e r_owner;
  logic       r_drop;
  logic       r_we;

  logic          r_if_rvalid;
  logic [DW-1:0] r_if_rdata;
  logic          r_dm_rvalid;
  logic [DW-1:0] r_dm_rdata;

  logic          w_idle;
  logic          w_wait;
  logic          w_eff_if;
  logic          w_at_limit;
  logic          w_sel_if;
  logic          w_sel_dm;
  logic          w_if_gnt;
  logic          w_dm_gnt;
  logic          w_any_gnt;
  logic          w_resp;
  logic          w_if_deliver;
  logic          w_dm_deliver;
  logic          w_starve_clr;
  logic          w_starve_inc;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;

  // Grants are also gated by reset so nothing is accepted while held in reset.
  assign w_idle   = (r_state == ARB_IDLE) && rst_n;
  assign w_wait   = (r_state == ARB_WAIT);
  assign w_eff_if = bus.if_req && !bus.if_flush;

  assign w_sel_if  = w_eff_if && (!bus.dm_req || w_at_limit);
  assign w_sel_dm  = !w_sel_if && bus.dm_req;
  assign w_if_gnt  = w_idle && w_sel_if && bus.mem_ready;
  assign w_dm_gnt  = w_idle && w_sel_dm && bus.mem_ready;
  assign w_any_gnt = w_if_gnt || w_dm_gnt;

  assign w_addr  = w_sel_dm ? bus.dm_addr : bus.if_addr;
  assign w_wdata = w_sel_dm ? bus.dm_wdata : '0;

  assign bus.mem_req   = w_idle && (w_sel_if || w_sel_dm);
  assign bus.mem_we    = w_sel_dm && bus.dm_we;
  assign bus.mem_be    = w_sel_dm ? bus.dm_be : '0;
  assign bus.mem_addr  = w_addr;
  assign bus.mem_wdata = w_wdata;

  assign bus.if_gnt    = w_if_gnt;
  assign bus.dm_gnt    = w_dm_gnt;
  assign bus.if_rvalid = r_if_rvalid;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.dm_rvalid = r_dm_rvalid;
  assign bus.dm_rdata  = r_dm_rdata;

  // A response only counts while a transaction is open; IDLE responses are stray.
  assign w_resp       = w_wait && bus.mem_rvalid;
  assign w_dm_deliver = w_resp && (r_owner == OWN_DM);
  assign w_if_deliver = w_resp && (r_owner == OWN_IF) && !r_drop && !bus.if_flush;

  // Every cycle fetch waits with a live request counts, including WAIT cycles.
  assign w_starve_clr = w_if_gnt || !bus.if_req;
  assign w_starve_inc = w_eff_if && ((w_idle && w_dm_gnt) || w_wait);

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_clr      (w_starve_clr),
    .i_inc      (w_starve_inc),
    .o_at_limit (w_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_any_gnt)       w_state_next = ARB_WAIT;
      ARB_WAIT: if (bus.mem_rvalid)  w_state_next = ARB_IDLE;
      default:                       w_state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= OWN_DM;
      r_drop  <= 1'b0;
      r_we    <= 1'b0;
    end else if (w_any_gnt) begin
      r_owner <= w_if_gnt ? OWN_IF : OWN_DM;
      r_drop  <= 1'b0;
      r_we    <= w_dm_gnt && bus.dm_we;
    end else if (w_wait && bus.if_flush && (r_owner == OWN_IF)) begin
      r_drop  <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_if_rvalid <= 1'b0;
      r_if_rdata  <= '0;
      r_dm_rvalid <= 1'b0;
      r_dm_rdata  <= '0;
    end else begin
      r_if_rvalid <= w_if_deliver;
      r_dm_rvalid <= w_dm_deliver;
      if (w_if_deliver) begin
        r_if_rdata <= bus.mem_rdata;
      end
      if (w_dm_deliver) begin
        r_dm_rdata <= r_we ? '0 : bus.mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven on the falling edge, outputs
// checked 1 time unit later, memory responses hand-scheduled per step.
module tb_mem_arbiter;

  logic clk;
  logic rst_n;
  int   n_total;
  int   n_pass;
  logic exp_if_win [4];

  mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_arbiter #(
    .AW           (32),
    .DW           (32),
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h, want %h", tag, obs, exp);
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    // Two DM transactions at latency 1 cost 4 waiting cycles for fetch.
    exp_if_win[0] = 1'b0;
    exp_if_win[1] = 1'b0;
    exp_if_win[2] = 1'b1;
    exp_if_win[3] = 1'b0;

    rst_n          = 1'b0;
    bus.if_req     = 1'b1;
    bus.if_addr    = 32'h0;
    bus.if_flush   = 1'b0;
    bus.dm_req     = 1'b1;
    bus.dm_we      = 1'b0;
    bus.dm_be      = 4'h0;
    bus.dm_addr    = 32'h10;
    bus.dm_wdata   = 32'h0;
    bus.mem_ready  = 1'b1;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;

    // Held in reset with both requests asserted.
    next_cycle();
    next_cycle();
    #1;
    chk("rst_if_gnt",    32'(bus.if_gnt),    32'h0);
    chk("rst_dm_gnt",    32'(bus.dm_gnt),    32'h0);
    chk("rst_mem_req",   32'(bus.mem_req),   32'h0);
    chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'h0);

    // Release: DM has priority, latency 1.
    next_cycle();
    rst_n = 1'b1;
    #1;
    chk("rel_dm_gnt", 32'(bus.dm_gnt), 32'h1);
    chk("rel_if_gnt", 32'(bus.if_gnt), 32'h0);
    next_cycle();
    bus.dm_req = 1'b0;
    bus.if_req = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    #1;
    chk("wait_no_gnt", 32'(bus.dm_gnt), 32'h0);
    chk("wait_no_req", 32'(bus.mem_req), 32'h0);
    next_cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("rel_dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("rel_dm_rdata",  bus.dm_rdata,       32'hDEADBEEF);
    chk("rel_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    $display("txn reset-release DM read rdata=%h", bus.dm_rdata);
    next_cycle();
    #1;
    chk("rel_dm_rvalid_pulse", 32'(bus.dm_rvalid), 32'h0);

    // Lone fetch at 0x40, latency 2.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    #1;
    chk("fetch_if_gnt",   32'(bus.if_gnt),   32'h1);
    chk("fetch_mem_addr", bus.mem_addr,      32'h40);
    chk("fetch_mem_we",   32'(bus.mem_we),   32'h0);
    chk("fetch_mem_req",  32'(bus.mem_req),  32'h1);
    next_cycle();
    bus.if_req = 1'b0;
    next_cycle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00000013;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("fetch_if_rvalid", 32'(bus.if_rvalid), 32'h1);
    chk("fetch_if_rdata",  bus.if_rdata,       32'h00000013);
    $display("txn fetch addr=40 rdata=%h", bus.if_rdata);
    next_cycle();
    #1;
    chk("fetch_rvalid_pulse", 32'(bus.if_rvalid), 32'h0);

    // Starvation guard: both requesters held high, latency 1.
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    bus.dm_req  = 1'b1;
    bus.dm_addr = 32'h180;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("starve_if_gnt", 32'(bus.if_gnt), 32'(exp_if_win[k]));
      chk("starve_dm_gnt", 32'(bus.dm_gnt), 32'(!exp_if_win[k]));
      if (k == 3) begin
        chk("starve_if_rvalid", 32'(bus.if_rvalid), 32'h1);
        chk("starve_if_rdata",  bus.if_rdata,       32'h1002);
      end
      $display("txn starve arb %0d if_gnt=%0b dm_gnt=%0b", k, bus.if_gnt, bus.dm_gnt);
      next_cycle();
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = 32'h1000 + 32'(k);
      next_cycle();
      bus.mem_rvalid = 1'b0;
    end
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    #1;
    chk("starve_dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("starve_dm_rdata",  bus.dm_rdata,       32'h1003);

    // Flush while IDLE masks the fetch request entirely.
    next_cycle();
    bus.if_req   = 1'b1;
    bus.if_flush = 1'b1;
    #1;
    chk("flush_idle_gnt", 32'(bus.if_gnt),  32'h0);
    chk("flush_idle_req", 32'(bus.mem_req), 32'h0);

    // Flush in flight: fetch at 0x44, flush during WAIT, response dropped.
    next_cycle();
    bus.if_flush = 1'b0;
    bus.if_addr  = 32'h44;
    #1;
    chk("flush_if_gnt", 32'(bus.if_gnt), 32'h1);
    next_cycle();
    bus.if_req   = 1'b0;
    bus.if_flush = 1'b1;
    next_cycle();
    bus.if_flush   = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00000BAD;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    bus.dm_req     = 1'b1;
    bus.dm_addr    = 32'h200;
    #1;
    chk("flush_if_rvalid", 32'(bus.if_rvalid), 32'h0);
    chk("flush_dm_gnt",    32'(bus.dm_gnt),    32'h1);
    $display("txn flushed fetch addr=44 dropped");
    next_cycle();
    bus.dm_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h000055AA;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("post_flush_dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("post_flush_dm_rdata",  bus.dm_rdata,       32'h000055AA);
    $display("txn DM read addr=200 rdata=%h", bus.dm_rdata);

    // Write: fields pass through, completion returns zero data.
    next_cycle();
    bus.dm_req   = 1'b1;
    bus.dm_we    = 1'b1;
    bus.dm_be    = 4'b0011;
    bus.dm_addr  = 32'h100;
    bus.dm_wdata = 32'h1234;
    #1;
    chk("wr_dm_gnt",    32'(bus.dm_gnt), 32'h1);
    chk("wr_mem_we",    32'(bus.mem_we), 32'h1);
    chk("wr_mem_be",    32'(bus.mem_be), 32'h3);
    chk("wr_mem_addr",  bus.mem_addr,    32'h100);
    chk("wr_mem_wdata", bus.mem_wdata,   32'h1234);
    next_cycle();
    bus.dm_req     = 1'b0;
    bus.dm_we      = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hFFFFFFFF;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("wr_dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("wr_dm_rdata",  bus.dm_rdata,       32'h0);
    $display("txn DM write addr=100 be=0011 wdata=1234");

    // Stray response in IDLE is ignored.
    next_cycle();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000CAFE;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("spur_dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("spur_if_rvalid", 32'(bus.if_rvalid), 32'h0);

    // Memory not ready for 3 cycles, then grant, then reset mid-WAIT.
    bus.mem_ready = 1'b0;
    bus.dm_req    = 1'b1;
    bus.dm_addr   = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("nrdy_dm_gnt",  32'(bus.dm_gnt),  32'h0);
      chk("nrdy_mem_req", 32'(bus.mem_req), 32'h1);
      next_cycle();
    end
    bus.mem_ready = 1'b1;
    #1;
    chk("rdy_dm_gnt", 32'(bus.dm_gnt), 32'h1);
    next_cycle();
    bus.dm_req = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("midrst_dm_rvalid", 32'(bus.dm_rvalid), 32'h0);
    next_cycle();
    rst_n          = 1'b1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0000DEAD;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    bus.dm_req     = 1'b1;
    bus.dm_addr    = 32'h304;
    #1;
    chk("midrst_no_rvalid", 32'(bus.dm_rvalid), 32'h0);
    chk("midrst_idle_gnt",  32'(bus.dm_gnt),    32'h1);
    $display("txn DM read addr=300 cancelled by reset");
    next_cycle();
    bus.dm_req     = 1'b0;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h00000077;
    next_cycle();
    bus.mem_rvalid = 1'b0;
    #1;
    chk("final_dm_rvalid", 32'(bus.dm_rvalid), 32'h1);
    chk("final_dm_rdata",  bus.dm_rdata,       32'h00000077);
    $display("txn DM read addr=304 rdata=%h", bus.dm_rdata);

    next_cycle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
